e203_exu_fpu_fmac_disp: RTL and testbench
=========================================

E203_EXU_FPU_FMAC_DISP -- requirements
Module: e203_exu_fpu_fmac_disp

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 255: WAIT-state cycle count that raises timeout_err (valid range 1..255).
REQ-002 SHALL provide clk  in  1  single clock; all state rises on posedge clk.
REQ-003 SHALL provide rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide req_valid  in  1, req_ready  out  1: request handshake from the EXU.
REQ-005 SHALL provide req_op  in  2  operation: 00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd.
REQ-006 SHALL provide req_rs1, req_rs2, req_rs3  in  32 each  IEEE single-precision operands.
REQ-007 SHALL provide req_rd  in  5  destination register index.
REQ-008 SHALL provide fmac_mmnn_i_valid  out  1, fmac_mmnn_i_ready  in  1: operand handshake to the FMA engine.
REQ-009 SHALL provide fmac_i_rs1, fmac_i_rs2, fmac_i_rs3  out  32 each  engine operands.
REQ-010 SHALL provide fmac_mmnn_o_valid  in  1, fmac_mmnn_o_ready  out  1, fmac_mmnn_o_wbck_wdat  in  32: engine result.
REQ-011 SHALL provide wbck_valid  out  1, wbck_ready  in  1, wbck_wdat  out  32, wbck_rd  out  5: writeback port.
REQ-012 SHALL provide wbck_nan  out  1: set when the written-back result is NaN.
REQ-013 SHALL provide busy  out  1: set in any state other than IDLE.
REQ-014 SHALL provide timeout_err  out  1 (sticky) and timeout_clr  in  1.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, WAIT, WBCK. No request overlap is allowed: one operation at a time.
REQ-016 req_ready SHALL be 1 only in IDLE. req_valid&req_ready SHALL latch operands and rd and move to WAIT on the next cycle. req_valid outside IDLE SHALL be ignored.
REQ-017 Sign pre-conditioning at latch:
- fmsub: invert bit31 of rs3.
- fnmsub: invert bit31 of rs1.
- fnmadd: invert bit31 of rs1 and of rs3.
- rs2 is never modified.
REQ-018 In WAIT, fmac_mmnn_i_valid and fmac_mmnn_o_ready SHALL be 1, driven from registers, and fmac_i_rs1/2/3 SHALL stay stable. Outside WAIT they SHALL be 0.
REQ-019 Completion is the cycle in WAIT with fmac_mmnn_o_valid & fmac_mmnn_i_ready. On that cycle the block SHALL capture fmac_mmnn_o_wbck_wdat and move to WBCK. fmac_mmnn_i_valid SHALL be 0 in the following cycle.
REQ-020 Result canonicalization: exponent==0xFF with mantissa!=0 SHALL be written back as 0x7FC00000 with wbck_nan=1. All other values, including infinities, SHALL pass unchanged with wbck_nan=0.
REQ-021 In WBCK, wbck_valid SHALL be 1, with wbck_wdat and wbck_rd stable until wbck_ready. wbck_valid&wbck_ready SHALL return the FSM to IDLE the next cycle.
REQ-022 Minimum request-to-wbck_valid latency SHALL be 2 cycles plus engine latency. Back-to-back throughput SHALL be one operation per (engine latency + 3) cycles.
REQ-023 An 8-bit counter SHALL clear on WAIT entry and increment every WAIT cycle without completion, saturating at 255.
REQ-024 When the counter reaches TIMEOUT_CYC, timeout_err SHALL be set. The operation SHALL continue waiting and SHALL NOT abort.
REQ-025 timeout_clr SHALL clear timeout_err. If a set and timeout_clr occur in the same cycle, set SHALL win.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- the FSM to IDLE;
- all outputs and the counter to 0;
- operand registers to 0.
REQ-027 Reset mid-operation SHALL discard the in-flight operation with no writeback. req_ready SHALL be 1 on the first clock after rst_n deasserts.

Verification
REQ-028 fmadd: rs1=0x40000000, rs2=0x40400000, rs3=0x3F800000, rd=5; engine returns 0x40E00000 -> engine operands unchanged; wbck_wdat=0x40E00000, wbck_rd=5, wbck_nan=0.
REQ-029 fnmadd: rs1=0x40000000, rs3=0x3F800000 -> fmac_i_rs1=0xC0000000, fmac_i_rs3=0xBF800000. fmsub -> only rs3 sign flipped. fnmsub -> only rs1 sign flipped.
REQ-030 Engine returns 0xFFC00000 -> wbck_wdat=0x7FC00000, wbck_nan=1. Engine returns 0xFF800000 -> passed unchanged, wbck_nan=0.
REQ-031 wbck_ready held low 10 cycles while req_valid=1 -> wbck_valid, wbck_wdat and wbck_rd stable; req_ready=0; no second latch. After acceptance, req_ready=1 next cycle.
REQ-032 Engine stalls 300 cycles, TIMEOUT_CYC=255 -> timeout_err rises on WAIT cycle 255; completion still writes back. A timeout_clr pulse then clears it.
REQ-033 rst_n low during WAIT -> fmac_mmnn_i_valid, busy and wbck_valid go 0 immediately; no writeback after release.

Source files
------------

// File: rtl/e203_exu_fpu_fmac_disp.sv
// FMA dispatch: latches one request, sign-conditions the operands for the four
// fused ops, hands them to the FMA engine and writes back the canonicalized result.
module e203_exu_fpu_fmac_disp #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [31:0] req_rs3,
   input  logic [4:0]  req_rd,

   output logic        fmac_mmnn_i_valid,
   input  logic        fmac_mmnn_i_ready,
   output logic [31:0] fmac_i_rs1,
   output logic [31:0] fmac_i_rs2,
   output logic [31:0] fmac_i_rs3,

   input  logic        fmac_mmnn_o_valid,
   output logic        fmac_mmnn_o_ready,
   input  logic [31:0] fmac_mmnn_o_wbck_wdat,

   output logic        wbck_valid,
   input  logic        wbck_ready,
   output logic [31:0] wbck_wdat,
   output logic [4:0]  wbck_rd,
   output logic        wbck_nan,

   output logic        busy,
   output logic        timeout_err,
   input  logic        timeout_clr
);

   // State bits double as the registered handshake outputs (bit0 = WAIT, bit1 = WBCK)
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_WBCK = 2'b10;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [31:0] rs1_r;
   logic [31:0] rs2_r;
   logic [31:0] rs3_r;
   logic [4:0]  rd_r;
   logic [31:0] wdat_r;
   logic        nan_r;
   logic [7:0]  cnt;
   logic        err_r;

   logic        in_wait;
   logic        in_wbck;
   logic        req_hsk;
   logic        complete;
   logic        wbck_hsk;
   logic        res_nan;
   logic        to_set;
   logic        flip_rs1;
   logic        flip_rs3;

   assign in_wait  = state[0];
   assign in_wbck  = state[1];
   assign req_ready = rst_n & (state == ST_IDLE);
   assign req_hsk  = req_valid & req_ready;
   assign complete = in_wait & fmac_mmnn_o_valid & fmac_mmnn_i_ready;
   assign wbck_hsk = in_wbck & wbck_ready;

   assign flip_rs1 = req_op[1];
   assign flip_rs3 = req_op[0];

   assign res_nan  = (fmac_mmnn_o_wbck_wdat[30:23] == 8'hFF) &&
                     (fmac_mmnn_o_wbck_wdat[22:0] != 23'd0);

   // Fires on the WAIT cycle whose increment brings the counter to TIMEOUT_CYC
   assign to_set   = in_wait & ~complete & (cnt == 8'(TIMEOUT_CYC - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_hsk)  state_nxt = ST_WAIT;
         ST_WAIT: if (complete) state_nxt = ST_WBCK;
         ST_WBCK: if (wbck_hsk) state_nxt = ST_IDLE;
         default:               state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_r <= '0;
         rs2_r <= '0;
         rs3_r <= '0;
         rd_r  <= '0;
      end else if (req_hsk) begin
         rs1_r <= {req_rs1[31] ^ flip_rs1, req_rs1[30:0]};
         rs2_r <= req_rs2;
         rs3_r <= {req_rs3[31] ^ flip_rs3, req_rs3[30:0]};
         rd_r  <= req_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdat_r <= '0;
         nan_r  <= 1'b0;
      end else if (complete) begin
         wdat_r <= res_nan ? CANON_NAN : fmac_mmnn_o_wbck_wdat;
         nan_r  <= res_nan;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (req_hsk) begin
         cnt <= '0;
      end else if (in_wait && !complete && (cnt != 8'hFF)) begin
         cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (to_set) begin
         err_r <= 1'b1;
      end else if (timeout_clr) begin
         err_r <= 1'b0;
      end
   end

   assign fmac_mmnn_i_valid = in_wait;
   assign fmac_mmnn_o_ready = in_wait;
   assign fmac_i_rs1        = rs1_r & {32{in_wait}};
   assign fmac_i_rs2        = rs2_r & {32{in_wait}};
   assign fmac_i_rs3        = rs3_r & {32{in_wait}};

   assign wbck_valid  = in_wbck;
   assign wbck_wdat   = wdat_r;
   assign wbck_rd     = rd_r;
   assign wbck_nan    = nan_r;

   assign busy        = |state;
   assign timeout_err = err_r;

endmodule

// File: tb/tb_e203_exu_fpu_fmac_disp.sv
// Randomized bench for the FMA dispatcher with a transaction-level reference
// model of operand conditioning, result canonicalization and timeout behaviour.
module tb_e203_exu_fpu_fmac_disp;

   localparam int unsigned TO = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_rs1, req_rs2, req_rs3;
   logic [4:0]  req_rd;
   logic        fmac_mmnn_i_valid, fmac_mmnn_i_ready;
   logic [31:0] fmac_i_rs1, fmac_i_rs2, fmac_i_rs3;
   logic        fmac_mmnn_o_valid, fmac_mmnn_o_ready;
   logic [31:0] fmac_mmnn_o_wbck_wdat;
   logic        wbck_valid, wbck_ready;
   logic [31:0] wbck_wdat;
   logic [4:0]  wbck_rd;
   logic        wbck_nan;
   logic        busy, timeout_err, timeout_clr;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic        exp_err;

   always #5 clk = ~clk;

   e203_exu_fpu_fmac_disp #(.TIMEOUT_CYC(TO)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .req_op                (req_op),
      .req_rs1               (req_rs1),
      .req_rs2               (req_rs2),
      .req_rs3               (req_rs3),
      .req_rd                (req_rd),
      .fmac_mmnn_i_valid     (fmac_mmnn_i_valid),
      .fmac_mmnn_i_ready     (fmac_mmnn_i_ready),
      .fmac_i_rs1            (fmac_i_rs1),
      .fmac_i_rs2            (fmac_i_rs2),
      .fmac_i_rs3            (fmac_i_rs3),
      .fmac_mmnn_o_valid     (fmac_mmnn_o_valid),
      .fmac_mmnn_o_ready     (fmac_mmnn_o_ready),
      .fmac_mmnn_o_wbck_wdat (fmac_mmnn_o_wbck_wdat),
      .wbck_valid            (wbck_valid),
      .wbck_ready            (wbck_ready),
      .wbck_wdat             (wbck_wdat),
      .wbck_rd               (wbck_rd),
      .wbck_nan              (wbck_nan),
      .busy                  (busy),
      .timeout_err           (timeout_err),
      .timeout_clr           (timeout_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   function automatic logic [31:0] canon(input logic [31:0] v);
      return is_nan(v) ? 32'h7FC0_0000 : v;
   endfunction

   function automatic logic [31:0] rand_result();
      int unsigned sel;
      logic [31:0] v;
      sel = $urandom_range(0, 9);
      v   = $urandom;
      if (sel < 3)       v = {v[31], 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      else if (sel == 3) v = {v[31], 8'hFF, 23'd0};
      return v;
   endfunction

   task automatic idle_inputs();
      req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; req_rd = '0;
      fmac_mmnn_i_ready = 1'b0; fmac_mmnn_o_valid = 1'b0; fmac_mmnn_o_wbck_wdat = '0;
      wbck_ready = 1'b0; timeout_clr = 1'b0;
   endtask

   // One full operation; clr_k >= 0 pulses timeout_clr across the clr_k-th WAIT edge
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [4:0] rd, input int unsigned stall,
                         input logic [31:0] res, input int unsigned wb_hold, input int clr_k);
      logic [31:0] ea, ec, ew;
      logic        set_now;
      ea = (op == 2'b10 || op == 2'b11) ? {~a[31], a[30:0]} : a;
      ec = (op == 2'b01 || op == 2'b11) ? {~c[31], c[30:0]} : c;
      ew = canon(res);

      @(negedge clk);
      check("idle_req_ready", req_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_fmac_valid", fmac_mmnn_i_valid, 0);
      req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rs3 = c; req_rd = rd;
      @(negedge clk);

      for (int unsigned k = 0; k <= stall; k++) begin
         check("wait_i_valid", fmac_mmnn_i_valid, 1);
         check("wait_o_ready", fmac_mmnn_o_ready, 1);
         check("wait_rs1", fmac_i_rs1, ea);
         check("wait_rs2", fmac_i_rs2, b);
         check("wait_rs3", fmac_i_rs3, ec);
         check("wait_wbck_valid", wbck_valid, 0);
         check("wait_busy", busy, 1);
         check("wait_req_ready", req_ready, 0);
         check("wait_timeout", timeout_err, exp_err);
         req_valid = 1'($urandom_range(0, 1));
         req_op = 2'($urandom); req_rs1 = $urandom; req_rs2 = $urandom; req_rs3 = $urandom;
         req_rd = 5'($urandom);
         timeout_clr = (int'(k) == clr_k);
         if (k == stall) begin
            fmac_mmnn_o_valid = 1'b1; fmac_mmnn_i_ready = 1'b1; fmac_mmnn_o_wbck_wdat = res;
         end else begin
            case ($urandom_range(0, 2))
               0:       begin fmac_mmnn_o_valid = 1'b1; fmac_mmnn_i_ready = 1'b0; end
               1:       begin fmac_mmnn_o_valid = 1'b0; fmac_mmnn_i_ready = 1'b1; end
               default: begin fmac_mmnn_o_valid = 1'b0; fmac_mmnn_i_ready = 1'b0; end
            endcase
            fmac_mmnn_o_wbck_wdat = $urandom;
         end
         set_now = (k < stall) && (k + 1 == TO);
         if (set_now)          exp_err = 1'b1;
         else if (timeout_clr) exp_err = 1'b0;
         @(negedge clk);
      end
      timeout_clr = 1'b0;
      fmac_mmnn_o_valid = 1'b0; fmac_mmnn_i_ready = 1'b0; fmac_mmnn_o_wbck_wdat = $urandom;

      for (int unsigned w = 0; w <= wb_hold; w++) begin
         check("wbck_valid", wbck_valid, 1);
         check("wbck_wdat", wbck_wdat, ew);
         check("wbck_rd", wbck_rd, rd);
         check("wbck_nan", wbck_nan, is_nan(res));
         check("wbck_i_valid", fmac_mmnn_i_valid, 0);
         check("wbck_o_ready", fmac_mmnn_o_ready, 0);
         check("wbck_req_ready", req_ready, 0);
         check("wbck_timeout", timeout_err, exp_err);
         req_valid = 1'($urandom_range(0, 1));
         req_rs1 = $urandom; req_rd = 5'($urandom);
         wbck_ready = (w == wb_hold);
         @(negedge clk);
      end
      wbck_ready = 1'b0; req_valid = 1'b0;
      check("done_wbck_valid", wbck_valid, 0);
      check("done_req_ready", req_ready, 1);
      check("done_busy", busy, 0);
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      timeout_clr = 1'b1;
      @(negedge clk);
      timeout_clr = 1'b0;
      exp_err = 1'b0;
      check("clr_timeout", timeout_err, 0);
   endtask

   initial begin
      idle_inputs();
      exp_err = 1'b0;
      rst_n = 1'b0;
      #12;
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_i_valid", fmac_mmnn_i_valid, 0);
      check("rst_wbck_valid", wbck_valid, 0);
      check("rst_wbck_wdat", wbck_wdat, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_rs1", fmac_i_rs1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", req_ready, 1);

      // Directed vectors
      run_op(2'b00, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd5, 2, 32'h40E0_0000, 0, -1);
      run_op(2'b11, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd6, 0, 32'h1234_5678, 0, -1);
      run_op(2'b01, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd7, 1, 32'h0, 0, -1);
      run_op(2'b10, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd8, 3, 32'h8000_0000, 0, -1);
      run_op(2'b00, 32'h1, 32'h2, 32'h3, 5'd9, 1, 32'hFFC0_0000, 0, -1);
      run_op(2'b00, 32'h1, 32'h2, 32'h3, 5'd10, 1, 32'hFF80_0000, 0, -1);
      run_op(2'b01, 32'hC000_0000, 32'h1, 32'hBF80_0000, 5'd31, 0, 32'h7F80_0001, 10, -1);

      // Long stall: timeout rises, op still completes, pulse clears
      run_op(2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 5'd1, 300, 32'h3F80_0000, 1, -1);
      check("to_after_stall", timeout_err, 1);
      clear_pulse();
      // Clear coincident with the set edge: set wins
      run_op(2'b11, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 5'd2, 280, 32'h4000_0000, 0, int'(TO) - 1);
      clear_pulse();
      // Clear before threshold, stall just short of it: never set
      run_op(2'b10, 32'h5, 32'h6, 32'h7, 5'd3, TO - 1, 32'h4000_0000, 0, 100);

      // Randomized operations
      for (int i = 0; i < 60; i++) begin
         run_op(2'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                $urandom_range(0, 6), rand_result(), $urandom_range(0, 4), -1);
      end

      // Reset in the middle of WAIT
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'hDEAD_BEEF; req_rd = 5'd4;
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_i_valid", fmac_mmnn_i_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_i_valid", fmac_mmnn_i_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_wbck_valid", wbck_valid, 0);
      check("mid_rst_o_ready", fmac_mmnn_o_ready, 0);
      fmac_mmnn_o_valid = 1'b1; fmac_mmnn_i_ready = 1'b1; fmac_mmnn_o_wbck_wdat = 32'h4000_0000;
      @(negedge clk);
      rst_n = 1'b1;
      exp_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_mid_req_ready", req_ready, 1);
         check("post_mid_wbck_valid", wbck_valid, 0);
         check("post_mid_busy", busy, 0);
      end
      fmac_mmnn_o_valid = 1'b0; fmac_mmnn_i_ready = 1'b0;
      run_op(2'b01, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd12, 2, 32'h4110_0000, 1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
